// File: rtl/fp_unit_arbiter_if.sv
// Request/response and shared-unit signal bundle for fp_unit_arbiter.
// slave: the arbiter's view (consumes requests and unit status, drives the rest).
// master: the surrounding requesters and the shared unit.
interface fp_unit_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [32*NUM_REQ-1:0] req_datab;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_result;
  logic                  rsp_err;
  logic                  unit_enable;
  logic [31:0]           unit_dataa;
  logic [31:0]           unit_datab;
  logic [31:0]           unit_result;
  logic                  unit_done;
  logic                  busy;

  modport slave (
    input  req_valid, req_dataa, req_datab, unit_result, unit_done,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           unit_enable, unit_dataa, unit_datab, busy
  );

  modport master (
    output req_valid, req_dataa, req_datab, unit_result, unit_done,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           unit_enable, unit_dataa, unit_datab, busy
  );
endinterface

// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter/sequencer that time-multiplexes one multi-cycle FP unit
// (enable/done handshake) among NUM_REQ requesters. Operands are latched at the
// accept edge and held while the unit runs; the result is routed back only to
// the requester that issued it.
// Optional watchdog, enabled by defining FP_ARB_WATCHDOG_EN: if the unit does not
// signal done within WDOG_CYCLES busy cycles, the operation completes with a
// quiet NaN and rsp_err set.
module fp_unit_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  fp_unit_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp_unit_arbiter: NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("fp_unit_arbiter: GAP_CYCLES must be >= 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("fp_unit_arbiter: WDOG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   last_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [NUM_REQ-1:0] req_ready_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [31:0]        rsp_result_reg;
  logic               unit_enable_reg;
  logic [31:0]        unit_dataa_reg;
  logic [31:0]        unit_datab_reg;
  logic               busy_reg;

  // Candidate list in priority order: slot k holds requester (last+1+k) mod NUM_REQ.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_vld;
  logic [31:0]        opa [NUM_REQ];
  logic [31:0]        opb [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SUM_W-1:0] sum;
    assign sum          = {1'b0, last_reg} + SUM_W'(gi + 1);
    assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                   : IDX_W'(sum);
    assign cand_vld[gi] = bus.req_valid[cand_idx[gi]];
    assign opa[gi]      = bus.req_dataa[32*gi +: 32];
    assign opb[gi]      = bus.req_datab[32*gi +: 32];
  end

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] last_onehot;

  // Pick the first valid candidate after the last served requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign grant_onehot = NUM_REQ'(1) << grant_idx;
  assign last_onehot  = NUM_REQ'(1) << last_reg;

`ifdef FP_ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              rsp_err_reg;
  assign bus.rsp_err = rsp_err_reg;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Sequencer: accept in IDLE, run the unit in BUSY, enforce the enable-low gap in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_reg        <= IDX_W'(NUM_REQ - 1);
      gap_cnt_reg     <= '0;
      req_ready_reg   <= '0;
      rsp_valid_reg   <= '0;
      rsp_result_reg  <= '0;
      unit_enable_reg <= 1'b0;
      unit_dataa_reg  <= '0;
      unit_datab_reg  <= '0;
      busy_reg        <= 1'b0;
`ifdef FP_ARB_WATCHDOG_EN
      wdog_cnt_reg    <= '0;
      rsp_err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_valid_reg <= '0;
`ifdef FP_ARB_WATCHDOG_EN
          rsp_err_reg   <= 1'b0;
`endif
          if (grant_found) begin
            unit_dataa_reg  <= opa[grant_idx];
            unit_datab_reg  <= opb[grant_idx];
            unit_enable_reg <= 1'b1;
            req_ready_reg   <= grant_onehot;
            last_reg        <= grant_idx;
            busy_reg        <= 1'b1;
            state_reg       <= BUSY;
`ifdef FP_ARB_WATCHDOG_EN
            wdog_cnt_reg    <= '0;
`endif
          end else begin
            req_ready_reg <= '0;
          end
        end

        BUSY: begin
          req_ready_reg <= '0;
          if (bus.unit_done) begin
            rsp_result_reg  <= bus.unit_result;
            rsp_valid_reg   <= last_onehot;
            unit_enable_reg <= 1'b0;
            gap_cnt_reg     <= GAP_W'(GAP_CYCLES - 1);
            state_reg       <= GAP;
          end
`ifdef FP_ARB_WATCHDOG_EN
          else if (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1)) begin
            // Unit never answered: complete with a quiet NaN and flag it.
            rsp_result_reg  <= QNAN;
            rsp_err_reg     <= 1'b1;
            rsp_valid_reg   <= last_onehot;
            unit_enable_reg <= 1'b0;
            gap_cnt_reg     <= GAP_W'(GAP_CYCLES - 1);
            state_reg       <= GAP;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
          end
`endif
        end

        GAP: begin
          // unit_done is ignored here so a lingering done cannot finish the next op.
          rsp_valid_reg <= '0;
`ifdef FP_ARB_WATCHDOG_EN
          rsp_err_reg   <= 1'b0;
`endif
          if (gap_cnt_reg == '0) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end

        default: begin
          state_reg       <= IDLE;
          unit_enable_reg <= 1'b0;
          busy_reg        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_result  = rsp_result_reg;
  assign bus.unit_enable = unit_enable_reg;
  assign bus.unit_dataa  = unit_dataa_reg;
  assign bus.unit_datab  = unit_datab_reg;
  assign bus.busy        = busy_reg;

endmodule
